sys16_io_hub: RTL and testbench

- Parametrised memory-mapped I/O hub for the 16-bit single-board computer.
- Replaces ad-hoc switch/LED decoding with:
  - N input channels through synchronisers;
  - N registered output channels;
  - a compare timer with an interrupt flag.
- Sits on the CPU address/data bus beside sync ROM/RAM.
- Read data is registered with 1-cycle latency, the same latency as sync RAM, so the system read mux treats it like another memory.

---
 rtl/sys16_io_hub.sv | 238 +++++++++++++++++++++++
 tb/tb_sys16_io_hub.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sys16_io_hub.sv
// sys16_io_hub: memory-mapped I/O hub for the 16-bit single-board computer.
// It provides synchronised input channels, registered output channels and a
// compare timer with an interrupt flag, all in one 64-word window at IO_BASE.
// Read data is registered with one cycle of latency, the same as sync RAM.
// Optional build macro: SYS16_IO_DEBOUNCE_EN adds a per-channel debouncer
// behind the input synchronisers.
module sys16_io_hub #(
    parameter int          DATA_WIDTH = 16,
    parameter logic [15:0] IO_BASE    = 16'h2000,
    parameter int          N_IN       = 1,
    parameter int          N_OUT      = 1,
    parameter int          DEB_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [15:0]                   addr,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic                          we,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          hit,
    input  logic [N_IN*DATA_WIDTH-1:0]    in_bus,
    output logic [N_OUT*DATA_WIDTH-1:0]   out_bus,
    output logic                          irq
);

    localparam int         DW         = DATA_WIDTH;
    localparam logic [5:0] OFF_TCOUNT = 6'h20;
    localparam logic [5:0] OFF_TCMP   = 6'h21;
    localparam logic [5:0] OFF_TCTRL  = 6'h22;

    // Address decode
    logic       in_win;
    logic [5:0] off;
    logic       wr;
    logic       wr_tcount;
    logic       wr_tcmp;
    logic       wr_tctrl;

    assign in_win    = (addr[15:6] == IO_BASE[15:6]);
    assign off       = addr[5:0];
    assign wr        = we & in_win;
    assign wr_tcount = wr & (off == OFF_TCOUNT);
    assign wr_tcmp   = wr & (off == OFF_TCMP);
    assign wr_tctrl  = wr & (off == OFF_TCTRL);

    // Input synchroniser state
    logic [N_IN*DW-1:0] sync1_q;
    logic [N_IN*DW-1:0] sync2_q;
    logic [N_IN*DW-1:0] in_val;

    // Two-flop synchroniser on every input channel
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_bus;
            sync2_q <= sync1_q;
        end
    end

`ifdef SYS16_IO_DEBOUNCE_EN
    localparam int DCW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

    logic [N_IN*DW-1:0]           last_q;
    logic [N_IN*DW-1:0]           deb_q;
    logic [N_IN*DW-1:0]           deb_d;
    logic [N_IN-1:0][DCW-1:0]     cnt_q;
    logic [N_IN-1:0][DCW-1:0]     cnt_d;

    // Accept a channel value once it has held steady for DEB_CYCLES clocks
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int k = 0; k < N_IN; k++) begin
            if (sync2_q[k*DW +: DW] != last_q[k*DW +: DW]) begin
                cnt_d[k] = '0;
            end else if (sync2_q[k*DW +: DW] != deb_q[k*DW +: DW]) begin
                if (cnt_q[k] >= DCW'(DEB_CYCLES - 1)) begin
                    deb_d[k*DW +: DW] = sync2_q[k*DW +: DW];
                    cnt_d[k]          = '0;
                end else begin
                    cnt_d[k] = cnt_q[k] + DCW'(1);
                end
            end else begin
                cnt_d[k] = '0;
            end
        end
    end

    // Debouncer state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= '0;
            deb_q  <= '0;
            cnt_q  <= '0;
        end else begin
            last_q <= sync2_q;
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
        end
    end

    assign in_val = deb_q;
`else
    logic unused_deb;

    assign unused_deb = (DEB_CYCLES > 0);
    assign in_val     = sync2_q;
`endif

    // Output channel and timer state
    logic [N_OUT*DW-1:0] out_q;
    logic [N_OUT*DW-1:0] out_d;
    logic [DW-1:0]       tcount_q;
    logic [DW-1:0]       tcount_d;
    logic [DW-1:0]       tcmp_q;
    logic [DW-1:0]       tcmp_d;
    logic                en_q;
    logic                en_d;
    logic                ar_q;
    logic                ar_d;
    logic                irqen_q;
    logic                irqen_d;
    logic                match_q;
    logic                match_d;
    logic                cmp_hit;

    // Output channel writes
    always_comb begin
        out_d = out_q;
        for (int k = 0; k < N_OUT; k++) begin
            if (wr && (off == 6'(16 + k))) begin
                out_d[k*DW +: DW] = wdata;
            end
        end
    end

    // Timer next state: CPU write to TCOUNT beats increment/reload, and a
    // compare hit beats a write-1-clear of MATCH on the same edge
    always_comb begin
        tcount_d = tcount_q;
        tcmp_d   = tcmp_q;
        en_d     = en_q;
        ar_d     = ar_q;
        irqen_d  = irqen_q;
        match_d  = match_q;
        cmp_hit  = en_q && (tcount_q == tcmp_q);

        if (en_q) begin
            if (cmp_hit && ar_q) begin
                tcount_d = '0;
            end else begin
                tcount_d = tcount_q + DW'(1);
            end
        end
        if (wr_tcount) begin
            tcount_d = wdata;
        end
        if (wr_tcmp) begin
            tcmp_d = wdata;
        end
        if (wr_tctrl) begin
            en_d    = wdata[0];
            ar_d    = wdata[1];
            irqen_d = wdata[2];
            if (wdata[15]) begin
                match_d = 1'b0;
            end
        end
        if (cmp_hit) begin
            match_d = 1'b1;
        end
    end

    // Read mux, sampled from current register contents
    logic [DW-1:0] rd_d;
    logic [DW-1:0] rdata_q;
    logic          hit_q;

    always_comb begin
        rd_d = '0;
        if (in_win) begin
            for (int k = 0; k < N_IN; k++) begin
                if (off == 6'(k)) begin
                    rd_d = in_val[k*DW +: DW];
                end
            end
            for (int k = 0; k < N_OUT; k++) begin
                if (off == 6'(16 + k)) begin
                    rd_d = out_q[k*DW +: DW];
                end
            end
            case (off)
                OFF_TCOUNT: rd_d = tcount_q;
                OFF_TCMP:   rd_d = tcmp_q;
                OFF_TCTRL: begin
                    rd_d[0]  = en_q;
                    rd_d[1]  = ar_q;
                    rd_d[2]  = irqen_q;
                    rd_d[15] = match_q;
                end
                default: ;
            endcase
        end
    end

    // Register update; reset overrides any pending write, count or read
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q    <= '0;
            tcount_q <= '0;
            tcmp_q   <= '1;
            en_q     <= 1'b0;
            ar_q     <= 1'b0;
            irqen_q  <= 1'b0;
            match_q  <= 1'b0;
            rdata_q  <= '0;
            hit_q    <= 1'b0;
        end else begin
            out_q    <= out_d;
            tcount_q <= tcount_d;
            tcmp_q   <= tcmp_d;
            en_q     <= en_d;
            ar_q     <= ar_d;
            irqen_q  <= irqen_d;
            match_q  <= match_d;
            rdata_q  <= rd_d;
            hit_q    <= in_win;
        end
    end

    assign out_bus = out_q;
    assign rdata   = rdata_q;
    assign hit     = hit_q;
    assign irq     = match_q & irqen_q;

endmodule

// File: tb/tb_sys16_io_hub.sv
// Directed testbench for sys16_io_hub (default build, N_IN=2, N_OUT=2).
module tb_sys16_io_hub;

    logic        clk;
    logic        reset;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic [15:0] rdata;
    logic        hit;
    logic [31:0] in_bus;
    logic [31:0] out_bus;
    logic        irq;

    int nvec;
    int nerr;

    sys16_io_hub #(
        .DATA_WIDTH(16),
        .IO_BASE   (16'h2000),
        .N_IN      (2),
        .N_OUT     (2),
        .DEB_CYCLES(16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .wdata  (wdata),
        .we     (we),
        .rdata  (rdata),
        .hit    (hit),
        .in_bus (in_bus),
        .out_bus(out_bus),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a);
        addr = a;
        we   = 1'b0;
        tick();
    endtask

    initial begin
        nvec   = 0;
        nerr   = 0;
        reset  = 1'b1;
        addr   = 16'h0000;
        wdata  = 16'h0000;
        we     = 1'b0;
        in_bus = 32'h0;
        tick();
        tick();

        chk("rst_rdata", {16'h0, rdata}, 32'h0);
        chk("rst_hit", {31'h0, hit}, 32'h0);
        chk("rst_out", out_bus, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;

        rd(16'h2021);
        chk("rst_tcmp", {16'h0, rdata}, 32'h0000FFFF);
        chk("hit_tcmp", {31'h0, hit}, 32'h1);
        rd(16'h2022);
        chk("rst_tctrl", {16'h0, rdata}, 32'h0);
        rd(16'h2010);
        chk("rst_out0_rd", {16'h0, rdata}, 32'h0);

        wr(16'h2010, 16'hA5A5);
        chk("out_wr0", out_bus, 32'h0000A5A5);
        wr(16'h2011, 16'h1234);
        chk("out_wr1", out_bus, 32'h1234A5A5);
        rd(16'h2010);
        chk("out0_rd", {16'h0, rdata}, 32'h0000A5A5);
        chk("out0_hit", {31'h0, hit}, 32'h1);
        rd(16'h2011);
        chk("out1_rd", {16'h0, rdata}, 32'h00001234);
        wr(16'h2010, 16'h5A5A);
        rd(16'h2010);
        chk("rd_after_wr", {16'h0, rdata}, 32'h00005A5A);

        // Input channel 0: change lands on rdata three edges later
        addr = 16'h2000;
        in_bus[15:0] = 16'h00F0;
        tick();
        chk("in_lat1", {16'h0, rdata}, 32'h0);
        tick();
        chk("in_lat2", {16'h0, rdata}, 32'h0);
        tick();
        chk("in_lat3", {16'h0, rdata}, 32'h000000F0);
        in_bus[31:16] = 16'hBEEF;
        addr = 16'h2001;
        tick();
        tick();
        tick();
        chk("in_ch1", {16'h0, rdata}, 32'h0000BEEF);
        rd(16'h2002);
        chk("in_unmapped", {16'h0, rdata}, 32'h0);
        chk("in_unmapped_hit", {31'h0, hit}, 32'h1);

        // Timer: TCMP=5, EN|AUTORELOAD|IRQEN; TCOUNT=0 after enabling edge
        wr(16'h2021, 16'h0005);
        wr(16'h2022, 16'h0007);
        addr = 16'h2020;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("tmr_cnt", {16'h0, rdata}, 32'(i - 1));
            chk("tmr_irq", {31'h0, irq}, {31'h0, (i == 6)});
        end
        tick();
        chk("tmr_reload", {16'h0, rdata}, 32'h0);
        chk("tmr_irq_hold", {31'h0, irq}, 32'h1);
        wr(16'h2022, 16'h8007);
        chk("tmr_clear", {31'h0, irq}, 32'h0);
        addr = 16'h2020;
        for (int i = 9; i <= 12; i++) begin
            tick();
            chk("tmr_cnt2", {16'h0, rdata}, 32'(i - 7));
            chk("tmr_irq2", {31'h0, irq}, {31'h0, (i == 12)});
        end

        // Clear, then clear again exactly on the match edge: set wins
        wr(16'h2022, 16'h8007);
        chk("tmr_clear2", {31'h0, irq}, 32'h0);
        addr = 16'h2020;
        tick();
        tick();
        tick();
        tick();
        chk("tmr_pre_match", {16'h0, rdata}, 32'h4);
        chk("tmr_pre_irq", {31'h0, irq}, 32'h0);
        wr(16'h2022, 16'h8007);
        chk("set_beats_clear", {31'h0, irq}, 32'h1);

        // CPU write to TCOUNT beats increment
        wr(16'h2020, 16'h0003);
        rd(16'h2020);
        chk("tcount_wr", {16'h0, rdata}, 32'h3);

        // Stop and clear; TCOUNT freezes
        wr(16'h2022, 16'h8000);
        chk("stop_irq", {31'h0, irq}, 32'h0);
        rd(16'h2020);
        chk("freeze1", {16'h0, rdata}, 32'h5);
        rd(16'h2020);
        chk("freeze2", {16'h0, rdata}, 32'h5);
        rd(16'h2022);
        chk("tctrl_off", {16'h0, rdata}, 32'h0);

        // Unmapped offset vs outside window
        rd(16'h2030);
        chk("unmap_rd", {16'h0, rdata}, 32'h0);
        chk("unmap_hit", {31'h0, hit}, 32'h1);
        rd(16'h3000);
        chk("outside_rd", {16'h0, rdata}, 32'h0);
        chk("outside_hit", {31'h0, hit}, 32'h0);
        wr(16'h2030, 16'hFFFF);
        wr(16'h3000, 16'hFFFF);
        wr(16'h3010, 16'hFFFF);
        wr(16'h3021, 16'h0000);
        chk("ignored_out", out_bus, 32'h12345A5A);
        rd(16'h2021);
        chk("ignored_tcmp", {16'h0, rdata}, 32'h5);
        rd(16'h2020);
        chk("ignored_tcount", {16'h0, rdata}, 32'h5);
        rd(16'h2000);
        chk("in_still", {16'h0, rdata}, 32'h000000F0);

        // Reset overrides a pending write
        reset = 1'b1;
        addr  = 16'h2010;
        wdata = 16'h1111;
        we    = 1'b1;
        tick();
        chk("mid_rst_out", out_bus, 32'h0);
        chk("mid_rst_rdata", {16'h0, rdata}, 32'h0);
        chk("mid_rst_hit", {31'h0, hit}, 32'h0);
        reset = 1'b0;
        we    = 1'b0;
        rd(16'h2021);
        chk("post_rst_tcmp", {16'h0, rdata}, 32'h0000FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
